mips_div_unit: RTL and testbench



---
 rtl/mips_div_unit.sv | 147 ++++++++++++++
 tb/tb_mips_div_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mips_div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: quotient goes to LO, remainder to HI.
// Sign handling is done by converting operands to magnitudes first and fixing the signs afterwards.
module mips_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] orig_q, orig_d;
  logic             sgn_q, sgn_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quo_out_q, quo_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             dbz_out_q, dbz_out_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             qbit;

  // dvd_q doubles as the quotient shift register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign trial   = shifted + ~{1'b0, dsr_q} + {{WIDTH{1'b0}}, 1'b1};
  assign qbit    = ~trial[WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    orig_d    = orig_q;
    sgn_d     = sgn_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    dbz_d     = dbz_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    dbz_out_d = dbz_out_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          dvd_d   = dividend;
          dsr_d   = divisor;
          orig_d  = dividend;
          sgn_d   = is_signed;
          state_d = S_PREP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        if (sgn_q && dvd_q[WIDTH-1]) dvd_d = ~dvd_q + WIDTH'(1);
        if (sgn_q && dsr_q[WIDTH-1]) dsr_d = ~dsr_q + WIDTH'(1);
        negq_d  = sgn_q & (dvd_q[WIDTH-1] ^ dsr_q[WIDTH-1]);
        negr_d  = sgn_q & dvd_q[WIDTH-1];
        dbz_d   = (dsr_q == '0);
        rem_d   = '0;
        cnt_d   = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        rem_d = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], qbit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (dbz_q) begin
          quo_out_d = '1;
          rem_out_d = orig_q;
        end else begin
          quo_out_d = negq_q ? ~dvd_q + WIDTH'(1) : dvd_q;
          rem_out_d = negr_q ? ~rem_q + WIDTH'(1) : rem_q;
        end
        dbz_out_d = dbz_q;
        state_d   = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      orig_q    <= '0;
      sgn_q     <= 1'b0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      dbz_q     <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      orig_q    <= orig_d;
      sgn_q     <= sgn_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      dbz_q     <= dbz_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  assign busy        = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign quotient    = quo_out_q;
  assign remainder   = rem_out_q;
  assign div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_mips_div_unit.sv
// Scoreboard bench for mips_div_unit: stimulus queues expected results, a monitor checks each done pulse.
module tb_mips_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  typedef struct {
    string       name;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   dones  = 0;
  int   pushed = 0;

  mips_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      dones++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with q=0x%08h expected no result", quotient);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_q"}, quotient, e.q);
        chk({e.name, "_r"}, remainder, e.r);
        chk({e.name, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
      end
    end
  end

  task automatic push(input string name, input logic [31:0] q, input logic [31:0] r, input logic dbz);
    exp_t e;
    e.name = name;
    e.q    = q;
    e.r    = r;
    e.dbz  = dbz;
    exp_q.push_back(e);
    pushed++;
  endtask

  // Called one time step after the edge that sampled start; counts edges until done.
  task automatic wait_done(output int edges, output int busy_n);
    edges  = 0;
    busy_n = busy ? 1 : 0;
    while (edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) break;
      if (busy) busy_n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d edges expected done", edges);
    end
  endtask

  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    start     = 1'b1;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    start     = 1'b0;
    is_signed = ~sgn;
    dividend  = 32'hDEAD_BEEF;
    divisor   = 32'h0000_0000;
  endtask

  task automatic run_op(input string name, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r, input logic dbz);
    int edges, busy_n;
    @(posedge clk);
    #1;
    push(name, q, r, dbz);
    issue(sgn, a, b);
    wait_done(edges, busy_n);
    chk({name, "_latency"}, edges, 34);
    chk({name, "_busy_cycles"}, busy_n, 34);
  endtask

  initial begin
    int edges, busy_n;
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #12;
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_q", quotient, 0);
    chk("reset_r", remainder, 0);
    chk("reset_dbz", {31'd0, div_by_zero}, 0);
    #10 rst_n = 1'b1;

    run_op("divu_100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
    run_op("div_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
    run_op("div_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0);
    run_op("div_m100_m7",  1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0);
    run_op("div_ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0);
    run_op("divu_max_1",   1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0);
    run_op("divu_max_2",   1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          32'd1,          1'b0);
    run_op("div_dbz",      1'b1, 32'd1234,       32'd0,          32'hFFFF_FFFF,  32'h0000_04D2,  1'b1);
    run_op("divu_9_3",     1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0);

    // Second start while busy must be dropped.
    @(posedge clk);
    #1;
    push("hs_50_5", 32'd10, 32'd0, 1'b0);
    issue(1'b0, 32'd50, 32'd5);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    issue(1'b0, 32'd8, 32'd2);
    wait_done(edges, busy_n);
    chk("hs_latency", edges + 6, 34);

    // Start during the DONE cycle is accepted back-to-back.
    push("b2b_8_2", 32'd4, 32'd0, 1'b0);
    issue(1'b0, 32'd8, 32'd2);
    wait_done(edges, busy_n);
    chk("b2b_latency", edges, 34);
    chk("b2b_busy_cycles", busy_n, 34);

    run_op("divu_dbz", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);

    // Abort mid-iteration with reset; no result is expected from this start.
    @(posedge clk);
    #1;
    issue(1'b0, 32'd1000, 32'd3);
    repeat (11) @(posedge clk);
    #2;
    chk("pre_abort_busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_dbz", {31'd0, div_by_zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("divu_1000_3", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);

    @(posedge clk);
    #1;
    chk("pending_empty", exp_q.size(), 0);
    chk("done_count", dones, pushed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
